// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : score_tracker
//  Description : Clocked game score unit. Turns raw collision/miss levels into
//                single-count events, keeps a saturating score, the remaining
//                lives, the IDLE/PLAY/OVER game state and the session high
//                score. Feeds the seven-segment / VGA score display.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SCORE_W    : score / high-score width in bits
//    POINTS     : amount added per collision event
//    MAX_SCORE  : saturation ceiling, must be <= 2**SCORE_W-1
//    LIVES_INIT : lives loaded at game start (1..7)
//
//  Ports
//    clk        in   system clock
//    reset      in   synchronous active-high reset
//    start      in   level, begin or restart a game (ignored while playing)
//    collision  in   level, object hit; a held level counts once
//    miss       in   level, life lost; a held level counts once
//    score      out  current game score (SCORE_W)
//    high_score out  best score since reset (SCORE_W)
//    lives      out  remaining lives (3)
//    playing    out  high in PLAY state
//    game_over  out  high in OVER state
//    new_high   out  one-cycle pulse when high_score is updated
//    score_bcd  out  3-digit BCD copy of score (only with SCORE_BCD_EN)
//
//  Build option
//    SCORE_BCD_EN : when defined, adds the score_bcd output and its parallel
//                   BCD counter. Absent by default.
// ============================================================================
module score_tracker #(
  parameter int SCORE_W    = 8,
  parameter int POINTS     = 1,
  parameter int MAX_SCORE  = 255,
  parameter int LIVES_INIT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               collision,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [2:0]         lives,
  output logic               playing,
  output logic               game_over,
  output logic               new_high
`ifdef SCORE_BCD_EN
  ,
  output logic [11:0]        score_bcd
`endif
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  // Score arithmetic is done one bit wider than the score so that the sum
  // can exceed MAX_SCORE without wrapping before the clamp is applied.
  localparam logic [SCORE_W:0] c_POINTS_X   = (SCORE_W+1)'(POINTS);
  localparam logic [SCORE_W:0] c_MAX_X      = (SCORE_W+1)'(MAX_SCORE);
  localparam logic [2:0]       c_LIVES_INIT = 3'(LIVES_INIT);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_high;
  logic [2:0]         r_lives;
  logic               r_new_high;

  // Event history. The inputs are first captured (r_*_q) and then delayed
  // once more (r_*_d); the rising edge is detected between the two, so an
  // event reaches score/lives two clock edges after the input transition
  // and the raw inputs never feed the update logic directly.
  logic               r_coll_q;
  logic               r_coll_d;
  logic               r_miss_q;
  logic               r_miss_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic               w_coll_evt;
  logic               w_miss_evt;
  logic               w_last_life;
  logic [SCORE_W:0]   w_score_sum;
  logic [SCORE_W-1:0] w_score_sat;
  logic [SCORE_W-1:0] w_score_nxt;
  logic               w_beats_high;

  assign w_coll_evt  = r_coll_q & ~r_coll_d;
  assign w_miss_evt  = r_miss_q & ~r_miss_d;
  assign w_last_life = w_miss_evt && (r_lives == 3'd1);

  assign w_score_sum = {1'b0, r_score} + c_POINTS_X;
  assign w_score_sat = (w_score_sum > c_MAX_X) ? c_MAX_X[SCORE_W-1:0]
                                               : w_score_sum[SCORE_W-1:0];

  // Score as it will be after this cycle while playing. The high-score
  // compare uses this value so that a collision landing on the same cycle
  // as the final miss is counted in the final score.
  assign w_score_nxt  = w_coll_evt ? w_score_sat : r_score;
  assign w_beats_high = (w_score_nxt > r_high);

  // --------------------------------------------------------------------------
  // Edge-detect history: samples every cycle in every state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coll_q <= 1'b0;
      r_coll_d <= 1'b0;
      r_miss_q <= 1'b0;
      r_miss_d <= 1'b0;
    end else begin
      r_coll_q <= collision;
      r_coll_d <= r_coll_q;
      r_miss_q <= miss;
      r_miss_d <= r_miss_q;
    end
  end

  // --------------------------------------------------------------------------
  // Game FSM with score, lives and high score
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_score    <= '0;
      r_high     <= '0;
      r_lives    <= 3'd0;
      r_new_high <= 1'b0;
    end else begin
      r_new_high <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_PLAY;
            r_score <= '0;
            r_lives <= c_LIVES_INIT;
          end
        end

        S_PLAY: begin
          r_score <= w_score_nxt;
          if (w_miss_evt) begin
            r_lives <= r_lives - 3'd1;
          end
          // The high score is settled on the edge that enters OVER, so the
          // pulse coincides with the first cycle game_over is high.
          if (w_last_life) begin
            r_state <= S_OVER;
            if (w_beats_high) begin
              r_high     <= w_score_nxt;
              r_new_high <= 1'b1;
            end
          end
        end

        S_OVER: begin
          if (start) begin
            r_state <= S_PLAY;
            r_score <= '0;
            r_lives <= c_LIVES_INIT;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional BCD score counter
  // --------------------------------------------------------------------------
`ifdef SCORE_BCD_EN
  // Converts a non-negative integer below 1000 into three BCD digits.
  function automatic logic [11:0] f_to_bcd(input int unsigned v);
    int unsigned t;
    logic [11:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [11:0] c_BCD_POINTS = f_to_bcd(POINTS);
  localparam logic [11:0] c_BCD_CAP    = f_to_bcd((MAX_SCORE > 999) ? 999 : MAX_SCORE);

  logic [11:0] r_bcd;
  logic [11:0] w_bcd_sum;
  logic        w_bcd_ovf;
  logic [11:0] w_bcd_sat;

  // Digit-serial decimal add with carry between digits; a carry out of the
  // hundreds digit means the sum passed 999.
  always_comb begin
    logic [4:0] w_dsum;
    logic       w_carry;
    w_bcd_sum = '0;
    w_carry   = 1'b0;
    w_dsum    = '0;
    for (int i = 0; i < 3; i++) begin
      w_dsum = {1'b0, r_bcd[i*4 +: 4]} + {1'b0, c_BCD_POINTS[i*4 +: 4]}
             + {4'd0, w_carry};
      if (w_dsum > 5'd9) begin
        w_bcd_sum[i*4 +: 4] = 4'(w_dsum - 5'd10);
        w_carry             = 1'b1;
      end else begin
        w_bcd_sum[i*4 +: 4] = w_dsum[3:0];
        w_carry             = 1'b0;
      end
    end
    w_bcd_ovf = w_carry;
  end

  // Valid BCD compares correctly as a plain binary number.
  assign w_bcd_sat = (w_bcd_ovf || (w_bcd_sum > c_BCD_CAP)) ? c_BCD_CAP : w_bcd_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bcd <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_bcd <= '0;
          end
        end
        S_PLAY: begin
          if (w_coll_evt) begin
            r_bcd <= w_bcd_sat;
          end
        end
        default: begin
          r_bcd <= r_bcd;
        end
      endcase
    end
  end

  assign score_bcd = r_bcd;
`endif

  // --------------------------------------------------------------------------
  // Outputs: all driven from registers
  // --------------------------------------------------------------------------
  assign score      = r_score;
  assign high_score = r_high;
  assign lives      = r_lives;
  assign playing    = (r_state == S_PLAY);
  assign game_over  = (r_state == S_OVER);
  assign new_high   = r_new_high;

endmodule
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_tracker
//  Description : Directed self-checking bench for score_tracker with default
//                parameters (SCORE_W=8, POINTS=1, MAX_SCORE=255,
//                LIVES_INIT=3). Expected values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_tracker;

  logic       clk;
  logic       reset;
  logic       start;
  logic       collision;
  logic       miss;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [2:0] lives;
  logic       playing;
  logic       game_over;
  logic       new_high;
`ifdef SCORE_BCD_EN
  logic [11:0] score_bcd;
`endif

  int n_vec;
  int n_err;

  score_tracker #(
    .SCORE_W   (8),
    .POINTS    (1),
    .MAX_SCORE (255),
    .LIVES_INIT(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .collision (collision),
    .miss      (miss),
    .score     (score),
    .high_score(high_score),
    .lives     (lives),
    .playing   (playing),
    .game_over (game_over),
    .new_high  (new_high)
`ifdef SCORE_BCD_EN
    ,
    .score_bcd (score_bcd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    start = 1'b0;
    collision = 1'b0;
    miss = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One high cycle then one low cycle; the event lands on the second edge.
  task automatic pulse_coll(input int n);
    for (int i = 0; i < n; i++) begin
      collision = 1'b1;
      tick();
      collision = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_miss(input int n);
    for (int i = 0; i < n; i++) begin
      miss = 1'b1;
      tick();
      miss = 1'b0;
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    collision = 1'b0;
    miss = 1'b0;

    // Reset state
    reset_dut();
    check("rst_score", 32'(score), 0);
    check("rst_high", 32'(high_score), 0);
    check("rst_lives", 32'(lives), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_over", 32'(game_over), 0);
    check("rst_newhigh", 32'(new_high), 0);

    // Start, then a collision held for 20 cycles counts once
    start_game();
    check("start_playing", 32'(playing), 1);
    check("start_lives", 32'(lives), 3);
    check("start_score", 32'(score), 0);
    collision = 1'b1;
    tick();
    check("latency_1edge", 32'(score), 0);
    tick();
    check("latency_2edge", 32'(score), 1);
    repeat (18) tick();
    check("held_score", 32'(score), 1);
    check("held_lives", 32'(lives), 3);
    collision = 1'b0;
    tick();
    tick();

    // Separate pulses accumulate
    pulse_coll(4);
    check("five_pulses", 32'(score), 5);
`ifdef SCORE_BCD_EN
    check("bcd_five", 32'(score_bcd), 32'h005);
`endif

    // Start is ignored while playing
    start_game();
    check("start_in_play", 32'(score), 5);
    check("start_in_play_lives", 32'(lives), 3);

    // Saturation at MAX_SCORE, 260 pulses in total
    pulse_coll(245);
    check("score_250", 32'(score), 250);
    pulse_coll(10);
    check("score_sat", 32'(score), 255);
`ifdef SCORE_BCD_EN
    check("bcd_sat", 32'(score_bcd), 32'h255);
`endif

    // Three misses end the game
    pulse_miss(1);
    check("miss1_lives", 32'(lives), 2);
    check("miss1_over", 32'(game_over), 0);
    pulse_miss(1);
    check("miss2_lives", 32'(lives), 1);
    check("miss2_playing", 32'(playing), 1);
    pulse_miss(1);
    check("miss3_lives", 32'(lives), 0);
    check("miss3_over", 32'(game_over), 1);
    check("miss3_playing", 32'(playing), 0);
    check("miss3_high", 32'(high_score), 255);
    check("miss3_newhigh", 32'(new_high), 1);
    tick();
    check("newhigh_oneshot", 32'(new_high), 0);
    pulse_coll(1);
    check("coll_in_over", 32'(score), 255);
    check("coll_in_over_high", 32'(high_score), 255);

    // High score across three games
    reset_dut();
    start_game();
    pulse_coll(7);
    pulse_miss(3);
    check("g1_high", 32'(high_score), 7);
    check("g1_newhigh", 32'(new_high), 1);
    check("g1_over", 32'(game_over), 1);
    start_game();
    check("g2_start_score", 32'(score), 0);
    check("g2_start_lives", 32'(lives), 3);
    check("g2_start_playing", 32'(playing), 1);
    pulse_coll(7);
    pulse_miss(3);
    check("g2_high", 32'(high_score), 7);
    check("g2_newhigh", 32'(new_high), 0);
    check("g2_over", 32'(game_over), 1);
    start_game();
    pulse_coll(9);
    pulse_miss(3);
    check("g3_high", 32'(high_score), 9);
    check("g3_newhigh", 32'(new_high), 1);

    // Collision and final miss on the same cycle
    reset_dut();
    start_game();
    pulse_coll(4);
    pulse_miss(2);
    check("sim_pre_score", 32'(score), 4);
    check("sim_pre_lives", 32'(lives), 1);
    collision = 1'b1;
    miss = 1'b1;
    tick();
    collision = 1'b0;
    miss = 1'b0;
    tick();
    check("sim_score", 32'(score), 5);
    check("sim_over", 32'(game_over), 1);
    check("sim_lives", 32'(lives), 0);
    check("sim_high", 32'(high_score), 5);
    check("sim_newhigh", 32'(new_high), 1);

    // Reset in the middle of a game clears everything, high score included
    start_game();
    pulse_coll(12);
    check("mid_score", 32'(score), 12);
    check("mid_high_kept", 32'(high_score), 5);
`ifdef SCORE_BCD_EN
    check("bcd_twelve", 32'(score_bcd), 32'h012);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_score", 32'(score), 0);
    check("midrst_high", 32'(high_score), 0);
    check("midrst_lives", 32'(lives), 0);
    check("midrst_playing", 32'(playing), 0);
    check("midrst_over", 32'(game_over), 0);
    check("midrst_newhigh", 32'(new_high), 0);

    // Events in IDLE are ignored
    pulse_coll(2);
    pulse_miss(1);
    check("idle_score", 32'(score), 0);
    check("idle_lives", 32'(lives), 0);
    check("idle_playing", 32'(playing), 0);

`ifdef SCORE_BCD_EN
    // BCD copy of a three-digit score
    start_game();
    pulse_coll(123);
    check("bcd_123_score", 32'(score), 123);
    check("bcd_123", 32'(score_bcd), 32'h123);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
